// File: rtl/arm_exec_pipe.sv
// arm_exec_pipe: two-stage ARM32 execute unit (operand-2 shifter, ALU, CPSR flags).
// Optional macro ARM_EXEC_COND_EN enables evaluation of i_cond against the flag register.
module arm_exec_pipe #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [3:0]   i_cond,
    input  logic [3:0]   i_opc,
    input  logic         i_s_bit,
    input  logic         i_imm,
    input  logic [11:0]  i_op2,
    input  logic [N-1:0] i_v_rn,
    input  logic [N-1:0] i_v_rm,
    input  logic [N-1:0] i_v_rs,
    input  logic         i_flush,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_res,
    output logic         o_wb_en,
    output logic         o_executed,
    output logic [3:0]   o_nzcv
);

    typedef enum logic [3:0] {
        OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
        OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
        OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
        OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
    } opc_t;

    typedef enum logic [1:0] {SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3} shift_t;

    function automatic logic [N-1:0] ror_n(input logic [N-1:0] v, input int unsigned m);
        if (m == 0) return v;
        return (v >> m) | (v << (N - m));
    endfunction

    logic         s1_valid;
    opc_t         s1_opc;
    logic         s1_s;
    logic [N-1:0] s1_rn;
    logic [N-1:0] s1_op2;
    logic         s1_sh_c;
    logic         s1_use_c;
    logic         s1_rrx;
    logic [3:0]   flags;

    logic         advance;
    logic         accept;
    assign advance = ~o_valid | i_ready;
    assign o_ready = ~i_flush & (~s1_valid | advance);
    assign accept  = i_valid & o_ready;
    assign o_nzcv  = flags;

    shift_t       sh_type;
    int unsigned  sh_amt;
    logic [N:0]   wide;
    logic [N-1:0] sh_val;
    logic         sh_c;
    logic         sh_use_c;
    logic         sh_rrx;

    always_comb begin
        sh_type  = shift_t'(i_op2[6:5]);
        sh_amt   = 0;
        wide     = '0;
        sh_val   = '0;
        sh_c     = 1'b0;
        sh_use_c = 1'b0;
        sh_rrx   = 1'b0;
        if (i_imm) begin
            sh_val   = ror_n({{(N-8){1'b0}}, i_op2[7:0]}, {27'd0, i_op2[11:8], 1'b0});
            sh_c     = sh_val[N-1];
            sh_use_c = (i_op2[11:8] == 4'd0);
        end else begin
            if (i_op2[4]) begin
                sh_amt = {24'd0, i_v_rs[7:0]};
            end else begin
                sh_amt = {27'd0, i_op2[11:7]};
                if (sh_amt == 0 && (sh_type == SH_LSR || sh_type == SH_ASR)) sh_amt = N;
            end
            if (sh_amt == 0) begin
                if (!i_op2[4] && sh_type == SH_ROR) begin
                    // RRX: the MSB is filled from C when the instruction reaches S2.
                    sh_val = {1'b0, i_v_rm[N-1:1]};
                    sh_c   = i_v_rm[0];
                    sh_rrx = 1'b1;
                end else begin
                    sh_val   = i_v_rm;
                    sh_use_c = 1'b1;
                end
            end else begin
                // One guard bit carries the shifter carry; oversized amounts fall out as 0 / sign fill.
                case (sh_type)
                    SH_LSL: begin
                        wide   = {1'b0, i_v_rm} << sh_amt;
                        sh_val = wide[N-1:0];
                        sh_c   = wide[N];
                    end
                    SH_LSR: begin
                        wide   = {i_v_rm, 1'b0} >> sh_amt;
                        sh_val = wide[N:1];
                        sh_c   = wide[0];
                    end
                    SH_ASR: begin
                        wide   = $signed({i_v_rm, 1'b0}) >>> sh_amt;
                        sh_val = wide[N:1];
                        sh_c   = wide[0];
                    end
                    default: begin
                        sh_val = ror_n(i_v_rm, sh_amt % N);
                        sh_c   = sh_val[N-1];
                    end
                endcase
            end
        end
    end

    logic         c_flag;
    logic [N-1:0] op_b;
    logic         shc;
    logic [N-1:0] alu_x;
    logic [N-1:0] alu_y;
    logic         alu_cin;
    logic         arith;
    logic [N:0]   sum;
    logic [N-1:0] alu_res;
    logic         alu_v;
    logic         is_test;
    logic         cond_pass;
    logic         flag_we;
    logic [3:0]   new_flags;

    assign c_flag = flags[1];

    always_comb begin
        op_b    = s1_rrx ? {c_flag, s1_op2[N-2:0]} : s1_op2;
        shc     = s1_use_c ? c_flag : s1_sh_c;
        alu_x   = s1_rn;
        alu_y   = op_b;
        alu_cin = 1'b0;
        arith   = 1'b1;
        case (s1_opc)
            OP_SUB, OP_CMP: begin alu_y = ~op_b; alu_cin = 1'b1;   end
            OP_RSB:         begin alu_x = ~s1_rn; alu_cin = 1'b1;  end
            OP_ADC:         begin alu_cin = c_flag;                end
            OP_SBC:         begin alu_y = ~op_b; alu_cin = c_flag; end
            OP_RSC:         begin alu_x = ~s1_rn; alu_cin = c_flag; end
            OP_ADD, OP_CMN: begin alu_cin = 1'b0;                  end
            default:        begin arith = 1'b0;                    end
        endcase
        sum   = {1'b0, alu_x} + {1'b0, alu_y} + {{N{1'b0}}, alu_cin};
        alu_v = (alu_x[N-1] == alu_y[N-1]) && (sum[N-1] != alu_x[N-1]);
        case (s1_opc)
            OP_AND, OP_TST: alu_res = s1_rn & op_b;
            OP_EOR, OP_TEQ: alu_res = s1_rn ^ op_b;
            OP_ORR:         alu_res = s1_rn | op_b;
            OP_MOV:         alu_res = op_b;
            OP_BIC:         alu_res = s1_rn & ~op_b;
            OP_MVN:         alu_res = ~op_b;
            default:        alu_res = sum[N-1:0];
        endcase
    end

`ifdef ARM_EXEC_COND_EN
    logic [3:0] s1_cond;
    logic       unused_bits;
    assign unused_bits = ^{i_v_rs[N-1:8], i_op2[3:0]};

    always_comb begin
        case (s1_cond)
            4'h0:    cond_pass = flags[2];
            4'h1:    cond_pass = ~flags[2];
            4'h2:    cond_pass = flags[1];
            4'h3:    cond_pass = ~flags[1];
            4'h4:    cond_pass = flags[3];
            4'h5:    cond_pass = ~flags[3];
            4'h6:    cond_pass = flags[0];
            4'h7:    cond_pass = ~flags[0];
            4'h8:    cond_pass = flags[1] & ~flags[2];
            4'h9:    cond_pass = ~flags[1] | flags[2];
            4'hA:    cond_pass = (flags[3] == flags[0]);
            4'hB:    cond_pass = (flags[3] != flags[0]);
            4'hC:    cond_pass = ~flags[2] & (flags[3] == flags[0]);
            4'hD:    cond_pass = flags[2] | (flags[3] != flags[0]);
            default: cond_pass = 1'b1;
        endcase
    end
`else
    logic unused_bits;
    assign unused_bits = ^{i_v_rs[N-1:8], i_op2[3:0], i_cond};
    assign cond_pass   = 1'b1;
`endif

    assign is_test   = (s1_opc[3:2] == 2'b10);
    assign flag_we   = cond_pass & (is_test | s1_s);
    assign new_flags = {alu_res[N-1], alu_res == '0, arith ? sum[N] : shc, arith ? alu_v : flags[0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_opc     <= OP_AND;
            s1_s       <= 1'b0;
            s1_rn      <= '0;
            s1_op2     <= '0;
            s1_sh_c    <= 1'b0;
            s1_use_c   <= 1'b0;
            s1_rrx     <= 1'b0;
`ifdef ARM_EXEC_COND_EN
            s1_cond    <= 4'hE;
`endif
            o_valid    <= 1'b0;
            o_res      <= '0;
            o_wb_en    <= 1'b0;
            o_executed <= 1'b0;
            flags      <= '0;
        end else begin
            if (i_flush) begin
                s1_valid <= 1'b0;
            end else if (accept) begin
                s1_valid <= 1'b1;
                s1_opc   <= opc_t'(i_opc);
                s1_s     <= i_s_bit;
                s1_rn    <= i_v_rn;
                s1_op2   <= sh_val;
                s1_sh_c  <= sh_c;
                s1_use_c <= sh_use_c;
                s1_rrx   <= sh_rrx;
`ifdef ARM_EXEC_COND_EN
                s1_cond  <= i_cond;
`endif
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            if (i_flush) begin
                o_valid <= 1'b0;
            end else if (advance) begin
                o_valid <= s1_valid;
                if (s1_valid) begin
                    o_res      <= alu_res;
                    o_wb_en    <= cond_pass & ~is_test;
                    o_executed <= cond_pass;
                    if (flag_we) flags <= new_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_arm_exec_pipe.sv
// Directed, table-driven bench for arm_exec_pipe (N=32) plus stall, flush and reset sequences.
module tb_arm_exec_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_cond;
    logic [3:0]  i_opc;
    logic        i_s_bit;
    logic        i_imm;
    logic [11:0] i_op2;
    logic [31:0] i_v_rn;
    logic [31:0] i_v_rm;
    logic [31:0] i_v_rs;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_res;
    logic        o_wb_en;
    logic        o_executed;
    logic [3:0]  o_nzcv;

    always #5 clk = ~clk;

    arm_exec_pipe #(.N(32)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_cond(i_cond), .i_opc(i_opc), .i_s_bit(i_s_bit), .i_imm(i_imm), .i_op2(i_op2),
        .i_v_rn(i_v_rn), .i_v_rm(i_v_rm), .i_v_rs(i_v_rs), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res), .o_wb_en(o_wb_en),
        .o_executed(o_executed), .o_nzcv(o_nzcv)
    );

    typedef struct {
        logic [3:0]  cond;
        logic [3:0]  opc;
        logic        s;
        logic        imm;
        logic [11:0] op2;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [31:0] rs;
        logic        chk_res;
        logic [31:0] res;
        logic [3:0]  nzcv;
        logic        wb;
        logic        ex;
    } vec_t;

    vec_t vq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] cond, input logic [3:0] opc, input logic s,
                                input logic imm, input logic [11:0] op2, input logic [31:0] rn,
                                input logic [31:0] rm, input logic [31:0] rs, input logic chk,
                                input logic [31:0] res, input logic [3:0] nzcv, input logic wb,
                                input logic ex);
        vec_t v;
        v.cond = cond; v.opc = opc; v.s = s; v.imm = imm; v.op2 = op2;
        v.rn = rn; v.rm = rm; v.rs = rs; v.chk_res = chk; v.res = res;
        v.nzcv = nzcv; v.wb = wb; v.ex = ex;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        i_cond = v.cond; i_opc = v.opc; i_s_bit = v.s; i_imm = v.imm; i_op2 = v.op2;
        i_v_rn = v.rn; i_v_rm = v.rm; i_v_rs = v.rs;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int waits;
        int acc;
        int outs;
        int drop_at;

        reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_flush = 1'b0;
        drive(mk(4'hE, 4'h0, 0, 0, 12'h000, 0, 0, 0, 0, 0, 4'h0, 0, 0));

        // cond opc S imm op2 rn rm rs | chk res nzcv wb ex
        vq.push_back(mk(4'hE, 4'h4, 1, 1, 12'h001, 32'h7FFFFFFF, 0, 0,           1, 32'h80000000, 4'h9, 1, 1));
        vq.push_back(mk(4'hE, 4'h2, 1, 1, 12'h005, 32'd5,        0, 0,           1, 32'h00000000, 4'h6, 1, 1));
        vq.push_back(mk(4'hE, 4'hD, 1, 1, 12'h4FF, 0,            0, 0,           1, 32'hFF000000, 4'hA, 1, 1));
        vq.push_back(mk(4'hE, 4'hD, 1, 0, 12'h020, 0, 32'h80000001, 0,           1, 32'h00000000, 4'h6, 1, 1));
        vq.push_back(mk(4'hE, 4'hD, 1, 0, 12'h060, 0, 32'h00000002, 0,           1, 32'h80000001, 4'h8, 1, 1));
        vq.push_back(mk(4'hE, 4'hD, 1, 0, 12'h010, 0, 32'h00000001, 32'd32,      1, 32'h00000000, 4'h6, 1, 1));
        vq.push_back(mk(4'hE, 4'hD, 1, 0, 12'h010, 0, 32'h00000001, 32'd33,      1, 32'h00000000, 4'h4, 1, 1));
        vq.push_back(mk(4'hE, 4'hA, 0, 1, 12'h003, 32'd3,        0, 0,           1, 32'h00000000, 4'h6, 0, 1));
`ifdef ARM_EXEC_COND_EN
        vq.push_back(mk(4'h1, 4'h4, 1, 1, 12'h001, 32'd1,        0, 0,           0, 32'h00000000, 4'h6, 0, 0));
`else
        vq.push_back(mk(4'h1, 4'h4, 1, 1, 12'h001, 32'd1,        0, 0,           1, 32'h00000002, 4'h0, 1, 1));
`endif
        vq.push_back(mk(4'hE, 4'h0, 1, 1, 12'h2FF, 32'hF0F0F0F0, 0, 0,           1, 32'hF0000000, 4'hA, 1, 1));
        vq.push_back(mk(4'hE, 4'h5, 1, 1, 12'h000, 32'hFFFFFFFE, 0, 0,           1, 32'hFFFFFFFF, 4'h8, 1, 1));
        vq.push_back(mk(4'hE, 4'h6, 1, 1, 12'h003, 32'd5,        0, 0,           1, 32'h00000001, 4'h2, 1, 1));
        vq.push_back(mk(4'hE, 4'h3, 1, 1, 12'h000, 32'd1,        0, 0,           1, 32'hFFFFFFFF, 4'h8, 1, 1));
        vq.push_back(mk(4'hE, 4'hB, 0, 0, 12'h000, 32'h80000000, 32'h80000000, 0, 1, 32'h00000000, 4'h7, 0, 1));
        vq.push_back(mk(4'hE, 4'hF, 1, 0, 12'h050, 0, 32'h80000000, 32'd40,      1, 32'h00000000, 4'h7, 1, 1));
        vq.push_back(mk(4'hE, 4'h1, 1, 0, 12'h070, 32'hFFFF0000, 32'h80000000, 32'd64, 1, 32'h7FFF0000, 4'h3, 1, 1));
        vq.push_back(mk(4'hE, 4'hC, 0, 0, 12'h260, 32'd1,        32'h0000000F, 0, 1, 32'hF0000001, 4'h3, 1, 1));
        vq.push_back(mk(4'hE, 4'hE, 1, 0, 12'h220, 32'hFFFFFFFF, 32'h000000F0, 0, 1, 32'hFFFFFFF0, 4'h9, 1, 1));
        vq.push_back(mk(4'hE, 4'h9, 0, 1, 12'h005, 32'd5,        0, 0,           1, 32'h00000000, 4'h5, 0, 1));
        vq.push_back(mk(4'hE, 4'h7, 1, 1, 12'h000, 32'd0,        0, 0,           1, 32'hFFFFFFFF, 4'h8, 1, 1));
        vq.push_back(mk(4'hE, 4'hD, 1, 0, 12'h100, 0, 32'h40000001, 0,           1, 32'h00000004, 4'h2, 1, 1));
        vq.push_back(mk(4'hE, 4'hD, 1, 0, 12'h040, 0, 32'h7FFFFFFF, 0,           1, 32'h00000000, 4'h4, 1, 1));
        vq.push_back(mk(4'hE, 4'h2, 1, 1, 12'h001, 32'h80000000, 0, 0,           1, 32'h7FFFFFFF, 4'h3, 1, 1));
        vq.push_back(mk(4'h6, 4'h4, 0, 1, 12'h001, 32'd1,        0, 0,           1, 32'h00000002, 4'h3, 1, 1));
`ifdef ARM_EXEC_COND_EN
        vq.push_back(mk(4'h3, 4'h4, 1, 1, 12'h001, 32'd1,        0, 0,           0, 32'h00000000, 4'h3, 0, 0));
`else
        vq.push_back(mk(4'h3, 4'h4, 1, 1, 12'h001, 32'd1,        0, 0,           1, 32'h00000002, 4'h0, 1, 1));
`endif

        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset o_valid", {31'd0, o_valid}, 32'd0);
        check("reset o_res", o_res, 32'd0);
        check("reset o_nzcv", {28'd0, o_nzcv}, 32'd0);
        check("reset o_wb_en", {31'd0, o_wb_en}, 32'd0);
        check("reset o_executed", {31'd0, o_executed}, 32'd0);
        check("reset o_ready", {31'd0, o_ready}, 32'd1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            i_valid = 1'b1;
            @(negedge clk);
            i_valid = 1'b0;
            waits = 0;
            while (!o_valid && waits < 8) begin
                @(negedge clk);
                waits++;
            end
            check($sformatf("v%0d latency", i), 32'(waits), 32'd1);
            if (vq[i].chk_res) check($sformatf("v%0d o_res", i), o_res, vq[i].res);
            check($sformatf("v%0d o_nzcv", i), {28'd0, o_nzcv}, {28'd0, vq[i].nzcv});
            check($sformatf("v%0d o_wb_en", i), {31'd0, o_wb_en}, {31'd0, vq[i].wb});
            check($sformatf("v%0d o_executed", i), {31'd0, o_executed}, {31'd0, vq[i].ex});
        end

        // Four back-to-back ADDs against an output stall of three cycles.
        acc = 0; outs = 0; drop_at = -1;
        for (int cyc = 0; cyc < 30 && outs < 4; cyc++) begin
            @(negedge clk);
            i_ready = (cyc >= 3);
            if (acc < 4) begin
                drive(mk(4'hE, 4'h4, 0, 1, 12'h001, 32'(10 * (acc + 1)), 0, 0, 0, 0, 0, 0, 0));
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (o_valid && i_ready) begin
                check($sformatf("stall out%0d", outs), o_res, 32'(10 * (outs + 1) + 1));
                outs++;
            end
            if (i_valid && !o_ready && drop_at < 0) drop_at = acc;
            if (i_valid && o_ready) acc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("stall out count", 32'(outs), 32'd4);
        check("stall ready drop", 32'(drop_at), 32'd2);
        @(negedge clk);
        #1;
        check("stall no dup", {31'd0, o_valid}, 32'd0);

        // CMP then ADDSNE issued back-to-back.
        @(negedge clk);
        drive(mk(4'hE, 4'hA, 0, 1, 12'h003, 32'd3, 0, 0, 0, 0, 0, 0, 0));
        i_valid = 1'b1;
        @(negedge clk);
        drive(mk(4'h1, 4'h4, 1, 1, 12'h001, 32'd1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        check("b2b cmp valid", {31'd0, o_valid}, 32'd1);
        check("b2b cmp nzcv", {28'd0, o_nzcv}, 32'h6);
        check("b2b cmp wb", {31'd0, o_wb_en}, 32'd0);
        @(negedge clk);
        #1;
        check("b2b ne valid", {31'd0, o_valid}, 32'd1);
`ifdef ARM_EXEC_COND_EN
        check("b2b ne executed", {31'd0, o_executed}, 32'd0);
        check("b2b ne wb", {31'd0, o_wb_en}, 32'd0);
        check("b2b ne nzcv", {28'd0, o_nzcv}, 32'h6);
`else
        check("b2b ne executed", {31'd0, o_executed}, 32'd1);
        check("b2b ne res", o_res, 32'd2);
        check("b2b ne nzcv", {28'd0, o_nzcv}, 32'h0);
`endif

        // Flush with two instructions in flight while the output is stalled.
        @(negedge clk);
        i_ready = 1'b0;
        drive(mk(4'hE, 4'hD, 1, 1, 12'h4FF, 0, 0, 0, 0, 0, 0, 0, 0));
        i_valid = 1'b1;
        @(negedge clk);
        drive(mk(4'hE, 4'hD, 1, 1, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        i_valid = 1'b0;
        i_flush = 1'b1;
        #1;
        check("flush o_ready", {31'd0, o_ready}, 32'd0);
        check("flush pre valid", {31'd0, o_valid}, 32'd1);
        @(negedge clk);
        i_flush = 1'b0;
        #1;
        check("flush o_valid", {31'd0, o_valid}, 32'd0);
        check("flush nzcv", {28'd0, o_nzcv}, 32'hA);
        i_ready = 1'b1;
        @(negedge clk);
        #1;
        check("flush no output", {31'd0, o_valid}, 32'd0);
        check("flush nzcv kept", {28'd0, o_nzcv}, 32'hA);

        // Reset while an instruction is in flight.
        @(negedge clk);
        drive(mk(4'hE, 4'h4, 1, 1, 12'h001, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0, 0));
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midreset o_valid", {31'd0, o_valid}, 32'd0);
        check("midreset nzcv", {28'd0, o_nzcv}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("midreset dropped", {31'd0, o_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm_exec_pipe.md
# arm_exec_pipe

Two-stage pipelined execute unit for the ARM32 core: full ARM operand-2 shifter with carry-out, all 16 data-processing opcodes, internal CPSR flag register, and in-block condition evaluation. It sits between decode and memory/write-back and uses a valid/ready handshake on both sides, so the core can stall and flush it. It generalises the existing single-cycle shifter/ALU path to width `N`, adds register-specified shifts and RRX, and implements ARM-correct carry/overflow semantics.

## Interface
- `N`, 32: datapath width; must be ≥ 32.
- `clk` in 1: clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `i_valid` in 1: an instruction is presented.
- `o_ready` out 1: the unit accepts the instruction this cycle.
- `i_cond` in 4, `i_opc` in 4, `i_s_bit` in 1: condition field, opcode field (instr[24:21]) and S bit.
- `i_imm` in 1: operand 2 is a rotated immediate (instr[25]).
- `i_op2` in 12: instr[11:0].
- `i_v_rn`, `i_v_rm`, `i_v_rs` in N: register operands; `i_v_rs[7:0]` is the shift amount for register shifts.
- `i_flush` in 1: discard all in-flight instructions.
- `o_valid` out 1 / `i_ready` in 1: output handshake.
- `o_res` out N: ALU result. `o_wb_en` out 1: write `o_res` to Rd. `o_executed` out 1: the condition passed.
- `o_nzcv` out 4: current flag register.

## Operation
- Transfer rules: input transfer on `i_valid & o_ready`; output transfer on `o_valid & i_ready`.
- Stage S1 registers the shifted operand 2, the raw shifter carry, and a `use_c` marker. `use_c` is set when the carry (or the RRX MSB) must come from the C flag.
- Stage S2 is the output register. It is loaded from S1 through the condition check and the ALU. The flag register is written at the same edge.
- Immediate operand: `imm8 = op2[7:0]`, rotated right within N bits by `2*op2[11:8]`. Carry out is C when the rotate is 0, otherwise the result MSB.
- Immediate shift (`op2[4]=0`): amount `op2[11:7]`, type `op2[6:5]`.
  - LSL #0: value unchanged, carry = C.
  - LSR #0 means LSR #N. ASR #0 means ASR #N.
  - ROR #0 means RRX: `{C, rm[N-1:1]}`, carry = `rm[0]`.
- Register shift (`op2[4]=1`): amount `rs[7:0]`.
  - Amount 0: value unchanged, carry = C.
  - LSL/LSR by exactly N: result 0, carry = `rm[0]` or `rm[N-1]` respectively.
  - LSL/LSR by more than N: result 0, carry 0.
  - ASR by ≥ N: every bit equals `rm[N-1]`, carry = `rm[N-1]`.
  - ROR uses `amount mod N`. When the modulus is 0 and the amount is nonzero, the result is unchanged and carry = `rm[N-1]`.
- Opcodes: AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN, using the ARM encoding 0000–1111.
- Carry on subtracts is the inverted borrow (ARM semantics). V is computed for arithmetic ops only.
- Logical ops: C = shifter carry, V unchanged.
- TST/TEQ/CMP/CMN: `o_wb_en=0`; flags are written regardless of S.
- Other opcodes: flags are written only when S=1. `o_wb_en=1` when executed.
- Condition failed: the instruction still retires (`o_valid=1`) with `o_executed=0`, `o_wb_en=0`, and flags unchanged.
- Flush: clears S1 and S2 valid bits. `o_ready=0` during a flush cycle. The flag register is preserved.

## Timing
- Latency: accepted at edge k, visible in S2 (`o_valid=1`) from edge k+1+... specifically, it is accepted at edge k, moves S1→S2 at edge k+1, and `o_valid` is high after edge k+1.
- Throughput: 1 instruction per cycle.
- Stall: S2 advances when `~s2_valid | i_ready`. S1 advances into S2 under the same condition.
  - `o_ready = ~s1_valid | ~s2_valid | i_ready`.
  - S2 contents stay stable while `o_valid & ~i_ready`.
- Flag ordering: the condition check, `use_c` resolution and RRX all happen at the S1→S2 edge. They use the flag register, which already holds the result of every older instruction. No forwarding hazard exists for back-to-back flag producer/consumer pairs.
- Reset values: `o_valid=0`, `o_res=0`, `o_wb_en=0`, `o_executed=0`, `o_nzcv=0000`; S1 empty. `o_ready=1` from the first cycle after reset deasserts.
- Reset mid-operation drops in-flight instructions with no output transfer.
- `i_flush` together with an output stall: the flush wins and `o_valid` is 0 in the next cycle.

## Configuration
- `ARM_EXEC_COND_EN`
  - Defined: `i_cond` is evaluated against the flag register (EQ…LE, AL; 1111 is treated as AL).
  - Undefined: `i_cond` is ignored. Every instruction executes with `o_executed=1`, and the condition logic is not synthesised.

## Test plan
- Reset, then ADDS with rn=0x7FFFFFFF, immediate op2=0x001 → after 2 cycles `o_res=0x80000000`, `o_nzcv=1001`, `o_wb_en=1`.
- SUBS with rn=5, imm 5 → `o_res=0`, `o_nzcv=0110`. Immediate op2=0x4FF with MOVS → `o_res=0xFF000000`, `o_nzcv=1010`.
- MOVS with rm=0x80000001, LSR #0 (op2=0x020) → `o_res=0`, `o_nzcv=0110`. Issue MOVS rm=0x00000002 with ROR #0 (op2=0x060) back-to-back → `o_res=0x80000001`, `o_nzcv=1000`.
- Register shift: LSL with rs=32, rm=0x00000001, MOVS → `o_res=0`, C=1. Repeat with rs=33 → `o_res=0`, C=0.
- Issue 4 ADDs back-to-back with `i_ready` held low for 3 cycles → `o_ready` drops after 2 accepts; results emerge in order with none lost or duplicated.
- Issue CMP 3,3 then ADDNE → `o_executed=0`, `o_wb_en=0`, flags stay 0110 (with `ARM_EXEC_COND_EN`). Assert `i_flush` with 2 in flight → `o_valid=0` next cycle and flags unchanged.
